// File: rtl/segcap_pkg.sv
// Shared constants for the 7-segment capture block: glyph codes (gfedcba),
// digit count and the frame-assembly FSM state encoding.
package segcap_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph decoder: 7-segment pattern -> {valid, blank, nibble}.
// The all-off pattern is a legal blank digit (nibble 0, blank 1).
module seg7_decode
  import segcap_pkg::*;
(
  input  logic [6:0] glyph,
  output logic       valid,
  output logic       blank,
  output logic [3:0] nibble
);

  // table lookup; anything not in the table is flagged invalid
  always_comb begin
    valid  = 1'b1;
    blank  = 1'b0;
    nibble = 4'h0;
    case (glyph)
      GLYPH_0:     nibble = 4'h0;
      GLYPH_1:     nibble = 4'h1;
      GLYPH_2:     nibble = 4'h2;
      GLYPH_3:     nibble = 4'h3;
      GLYPH_4:     nibble = 4'h4;
      GLYPH_5:     nibble = 4'h5;
      GLYPH_6:     nibble = 4'h6;
      GLYPH_7:     nibble = 4'h7;
      GLYPH_8:     nibble = 4'h8;
      GLYPH_9:     nibble = 4'h9;
      GLYPH_A:     nibble = 4'hA;
      GLYPH_B:     nibble = 4'hB;
      GLYPH_C:     nibble = 4'hC;
      GLYPH_D:     nibble = 4'hD;
      GLYPH_E:     nibble = 4'hE;
      GLYPH_F:     nibble = 4'hF;
      GLYPH_BLANK: blank  = 1'b1;
      default:     valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_capture.sv
// Receive side of a multiplexed 4-digit 7-segment display. Inputs are
// registered, debounced by a stability counter, decoded and assembled into
// frames. Optional frame watchdog: define SEGCAP_TIMEOUT_EN.
// Interface contract: there is no handshake; each output pulse is one cycle
// wide, and data_out/blank_out already hold the new frame in the cycle
// frame_valid is high.
module segment_capture
  import segcap_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  segment,
  input  logic [3:0]  digit_sel,
  output logic [15:0] data_out,
  output logic [3:0]  blank_out,
  output logic        frame_valid,
  output logic        err_pattern,
  output logic        err_select,
  output logic        timeout
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [6:0]    seg_q;
  logic [3:0]    sel_q;
  logic [CW-1:0] stable_cnt;
  logic          match, accept;

  state_t        state, state_d;
  logic [3:0]    mask, mask_d, mask_base;
  logic [15:0]   shd_data, shd_data_d;
  logic [3:0]    shd_blank, shd_blank_d;

  logic          dec_valid, dec_blank;
  logic [3:0]    dec_nibble;
  logic          acc_valid, acc_sel_err, acc_pat_err;
  logic          wd_expire;

  assign match  = (segment == seg_q) && (digit_sel == sel_q);
  // one accept per stable period: only the step into saturation fires
  assign accept = match && (stable_cnt == CNT_LAST);

  // input sampling and stability counter
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q      <= '0;
      sel_q      <= '0;
      stable_cnt <= '0;
    end else begin
      seg_q <= segment;
      sel_q <= digit_sel;
      if (!match)
        stable_cnt <= '0;
      else if (stable_cnt != CNT_MAX)
        stable_cnt <= stable_cnt + CW'(1);
    end
  end

  seg7_decode u_decode (
    .glyph  (seg_q),
    .valid  (dec_valid),
    .blank  (dec_blank),
    .nibble (dec_nibble)
  );

  // select errors take priority over glyph errors; a blanking gap is ignored
  assign acc_sel_err = accept && (sel_q != 4'h0) && !$onehot(sel_q);
  assign acc_pat_err = accept && $onehot(sel_q) && !dec_valid;
  assign acc_valid   = accept && $onehot(sel_q) && dec_valid;

  // the mask is already clear while publishing, so an accept then starts a new frame
  assign mask_base = (state == ST_PUBLISH) ? 4'h0 : mask;

  // next-state, mask and shadow update
  always_comb begin
    state_d     = state;
    mask_d      = mask_base;
    shd_data_d  = shd_data;
    shd_blank_d = shd_blank;
    if (acc_sel_err || acc_pat_err) begin
      mask_d  = 4'h0;
      state_d = ST_IDLE;
    end else if (acc_valid) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_q[i]) begin
          shd_data_d[i*4 +: 4] = dec_nibble;
          shd_blank_d[i]       = dec_blank;
        end
      end
      mask_d  = mask_base | sel_q;
      state_d = (mask_d == 4'hF) ? ST_PUBLISH : ST_COLLECT;
    end else if (wd_expire) begin
      mask_d  = 4'h0;
      state_d = ST_IDLE;
    end else if (state == ST_PUBLISH) begin
      state_d = ST_IDLE;
    end
  end

  // state, shadow and output registers; the frame is copied out on entry to PUBLISH
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      mask        <= 4'h0;
      shd_data    <= '0;
      shd_blank   <= '0;
      data_out    <= '0;
      blank_out   <= '0;
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
      err_select  <= 1'b0;
    end else begin
      state       <= state_d;
      mask        <= (state_d == ST_PUBLISH) ? 4'h0 : mask_d;
      shd_data    <= shd_data_d;
      shd_blank   <= shd_blank_d;
      frame_valid <= (state_d == ST_PUBLISH);
      err_pattern <= acc_pat_err;
      err_select  <= acc_sel_err;
      if (state_d == ST_PUBLISH) begin
        data_out  <= shd_data_d;
        blank_out <= shd_blank_d;
      end
    end
  end

`ifdef SEGCAP_TIMEOUT_EN
  localparam logic [16:0] WD_LAST = 17'(TIMEOUT_CYCLES - 1);
  logic [16:0] wd_cnt;

  assign wd_expire = (state == ST_COLLECT) && (wd_cnt == WD_LAST);

  // watchdog: counts time spent in COLLECT, restarted by every valid digit
  always_ff @(posedge clock) begin
    if (reset || state != ST_COLLECT || acc_valid)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 17'd1;
  end

  // timeout pulse only when the watchdog actually abandoned the frame
  always_ff @(posedge clock) begin
    if (reset)
      timeout <= 1'b0;
    else
      timeout <= wd_expire && !acc_valid && !acc_sel_err && !acc_pat_err;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_segment_capture.sv
// Bench for segment_capture: directed and randomized display traffic
// against a digit-level model of the capture rules.
module tb_segment_capture;

  localparam int S  = 4;
  localparam int TO = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  segment;
  logic [3:0]  digit_sel;
  logic [15:0] data_out;
  logic [3:0]  blank_out;
  logic        frame_valid, err_pattern, err_select, timeout;

  segment_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .segment     (segment),
    .digit_sel   (digit_sel),
    .data_out    (data_out),
    .blank_out   (blank_out),
    .frame_valid (frame_valid),
    .err_pattern (err_pattern),
    .err_select  (err_select),
    .timeout     (timeout)
  );

  // clock
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // reference model state
  logic [3:0]  m_mask;
  logic [15:0] m_data_sh, m_data;
  logic [3:0]  m_blank_sh, m_blank;
  int          m_last, m_run;
  int          exp_ep, exp_es, exp_to;
  logic [19:0] exp_q [$];

  // observations
  int          obs_ep = 0, obs_es = 0, obs_to = 0;
  logic [19:0] obs_q [$];
  int          fv_at;

  // monitor: collect pulses away from the active edge
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (frame_valid === 1'b1) obs_q.push_back({blank_out, data_out});
      if (err_pattern === 1'b1) obs_ep++;
      if (err_select  === 1'b1) obs_es++;
      if (timeout     === 1'b1) obs_to++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = 4'h0; m_data_sh = '0; m_blank_sh = '0; m_data = '0; m_blank = '0;
    m_last = -1; m_run = 0;
  endtask

  // digit-level rule: what one accepted (glyph, select) does to the frame
  task automatic m_accept(input logic [6:0] g, input logic [3:0] s);
    bit ok, blk;
    logic [3:0] nib;
    int slot;
    if (s == 4'h0) return;
    if ($countones(s) > 1) begin exp_es++; m_mask = 4'h0; return; end
    ok = 0; blk = 0; nib = 4'h0;
    if (g == 7'h00) begin ok = 1; blk = 1; end
    for (int k = 0; k < 16; k++) if (glyph_tab[k] == g) begin ok = 1; nib = 4'(k); end
    if (!ok) begin exp_ep++; m_mask = 4'h0; return; end
    slot = 0;
    for (int k = 0; k < 4; k++) if (s[k]) slot = k;
    m_data_sh[slot*4 +: 4] = nib;
    m_blank_sh[slot]       = blk;
    m_mask[slot]           = 1'b1;
    if (m_mask == 4'hF) begin
      m_data = m_data_sh; m_blank = m_blank_sh;
      exp_q.push_back({m_blank, m_data});
      m_mask = 4'h0;
    end
  endtask

  // driver: present a value for n cycles; an accept needs S+1 identical cycles
  task automatic hold(input logic [6:0] g, input logic [3:0] s, input int n);
    int v, prev;
    v = int'({g, s});
    segment = g; digit_sel = s;
    prev = (v == m_last) ? m_run : 0;
    m_run = prev + n; m_last = v;
    if (prev < S + 1 && m_run >= S + 1) m_accept(g, s);
    fv_at = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); @(negedge clock);
      if (frame_valid === 1'b1 && fv_at < 0) fv_at = i;
    end
  endtask

  task automatic digit(input logic [3:0] nib, input logic [3:0] s);
    hold(glyph_tab[nib], s, 6);
    hold(7'h00, 4'h0, 2);
  endtask

  task automatic do_reset();
    segment = 7'h00; digit_sel = 4'h0; reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
  endtask

  // scoreboard: drain, then compare pulse counts, frames and held outputs
  task automatic checkpoint(input string tag);
    hold(7'h00, 4'h0, 8);
    #2;
    chk({tag, "_nframes"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_frame"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete(); exp_q.delete();
    chk({tag, "_err_pattern"}, obs_ep, exp_ep);
    chk({tag, "_err_select"}, obs_es, exp_es);
    chk({tag, "_timeout"}, obs_to, exp_to);
    chk({tag, "_data_out"}, data_out, m_data);
    chk({tag, "_blank_out"}, blank_out, m_blank);
  endtask

  initial begin
    logic [6:0] g;
    logic [3:0] s;
    int r;
    exp_ep = 0; exp_es = 0; exp_to = 0;
    model_reset();
    segment = 7'h00; digit_sel = 4'h0; reset = 1'b1;

    // reset state
    do_reset();
    chk("rst_data_out", data_out, 16'h0);
    chk("rst_blank_out", blank_out, 4'h0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_err_pattern", err_pattern, 1'b0);
    chk("rst_err_select", err_select, 1'b0);
    chk("rst_timeout", timeout, 1'b0);

    // 1: frame 1234, frame_valid the cycle after the completing accept
    digit(4'h1, 4'h8); digit(4'h2, 4'h4); digit(4'h3, 4'h2);
    hold(7'h66, 4'h1, 6);
    chk("t1_latency", fv_at, S);
    checkpoint("t1");
    chk("t1_data", data_out, 16'h1234);

    // 2: too-short hold must not load a digit
    hold(7'h5B, 4'h4, 3); hold(7'h00, 4'h0, 2);
    digit(4'h5, 4'h8); digit(4'h6, 4'h2); digit(4'h7, 4'h1);
    checkpoint("t2a");
    digit(4'h2, 4'h4);
    checkpoint("t2b");

    // 3: invalid glyph, then a full frame
    hold(7'h55, 4'h2, 6); hold(7'h00, 4'h0, 2);
    digit(4'h9, 4'h8); digit(4'h8, 4'h4); digit(4'h7, 4'h2); digit(4'h6, 4'h1);
    checkpoint("t3");

    // 4: multi-hot select discards a partial frame
    digit(4'hA, 4'h8); digit(4'hB, 4'h4);
    hold(7'h06, 4'h3, 6); hold(7'h00, 4'h0, 2);
    digit(4'hC, 4'h2); digit(4'hD, 4'h1);
    checkpoint("t4a");
    hold(7'h00, 4'h8, 6); hold(7'h00, 4'h0, 2);
    digit(4'hC, 4'h4); digit(4'hD, 4'h2); digit(4'hE, 4'h1);
    checkpoint("t4b");

    // randomized traffic
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 15; i++) begin
        r = $urandom_range(0, 99);
        if (r < 70)      g = glyph_tab[$urandom_range(0, 15)];
        else if (r < 85) g = 7'h00;
        else             g = 7'($urandom_range(0, 127));
        r = $urandom_range(0, 99);
        if (r < 75)      s = 4'(1 << $urandom_range(0, 3));
        else if (r < 85) s = 4'h0;
        else             s = 4'($urandom_range(0, 15));
        hold(g, s, $urandom_range(2, 8));
      end
      checkpoint("rand");
    end

    // 6: reset mid-frame after a completed frame
    digit(4'h1, 4'h8); digit(4'h2, 4'h4); digit(4'h3, 4'h2); digit(4'h4, 4'h1);
    checkpoint("t6a");
    digit(4'hA, 4'h8); digit(4'hB, 4'h4); digit(4'hC, 4'h2);
    do_reset();
    chk("t6_rst_data", data_out, 16'h0);
    chk("t6_rst_flags", {frame_valid, err_pattern, err_select, timeout}, 4'h0);
    digit(4'hA, 4'h8); digit(4'hB, 4'h4); digit(4'hC, 4'h2); digit(4'hD, 4'h1);
    checkpoint("t6b");
    chk("t6_data", data_out, 16'hABCD);

    // 5: stalled frame
    digit(4'h3, 4'h8); digit(4'h2, 4'h4); digit(4'h1, 4'h2);
    hold(7'h00, 4'h0, TO + 30);
`ifdef SEGCAP_TIMEOUT_EN
    exp_to++;
    m_mask = 4'h0;
`endif
    checkpoint("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
